// File: rtl/priority_code_decoder_pkg.sv
// priority_code_decoder_pkg: shared widths, FSM states and code-to-line mapping for the code decoder.
package priority_code_decoder_pkg;

    localparam int CODE_W = 4;
    localparam int LINES  = 16;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } state_e;

    // Line k of {ui_in, uio_in} carries code k, so the mapping is the identity.
    function automatic logic [CODE_W-1:0] code_to_line(input logic [CODE_W-1:0] code);
        return code;
    endfunction

endpackage

// File: rtl/priority_code_decoder_dec.sv
// code_onehot_dec: combinational expansion of a priority code into its one-hot line pattern.
module code_onehot_dec
    import priority_code_decoder_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [LINES-1:0]  onehot_o
);

    assign onehot_o = LINES'(1) << code_to_line(code_i);

endmodule

// File: rtl/priority_code_decoder.sv
// priority_code_decoder: accepts codes via valid/ready, holds the decoded line high,
// then enforces an all-zero guard gap, counting every accepted code.
module priority_code_decoder
    import priority_code_decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              code_ready,
    output logic [LINES-1:0]  onehot_out,
    output logic              active,
    output logic [7:0]        event_count
);

    localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LD  = 8'(GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [LINES-1:0] onehot_q, onehot_d;
    logic [7:0]       evt_q, evt_d;
    logic [LINES-1:0] dec;

    code_onehot_dec u_dec (
        .code_i   (code_in),
        .onehot_o (dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            onehot_q <= '0;
            evt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            evt_q    <= evt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        evt_d    = evt_q;
        case (state_q)
            IDLE: if (code_valid) begin
                onehot_d = dec;
                cnt_d    = HOLD_LD;
                evt_d    = evt_q + 8'd1;
                state_d  = HOLD;
            end
            HOLD: if (cnt_q == '0) begin
                onehot_d = '0;
                cnt_d    = GAP_CYCLES > 0 ? GAP_LD : '0;
                state_d  = GAP_CYCLES > 0 ? GAP : IDLE;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
            GAP: if (cnt_q == '0) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign code_ready  = state_q == IDLE;
    assign onehot_out  = onehot_q;
    assign active      = |onehot_q;
    assign event_count = evt_q;

endmodule

// File: tb/tb_priority_code_decoder.sv
// tb_priority_code_decoder: directed checks of handshake timing, reset and decode for both parameter sets.
module tb_priority_code_decoder;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  code0, code1;
    logic        v0, v1, r0, r1, a0, a1;
    logic [15:0] oh0, oh1;
    logic [7:0]  ev0, ev1;
    int          n_checks = 0;
    int          n_errors = 0;
    vec_t        tbl [16];

    always #5 clk = ~clk;

    priority_code_decoder u0 (
        .clk         (clk),
        .rst         (rst),
        .code_in     (code0),
        .code_valid  (v0),
        .code_ready  (r0),
        .onehot_out  (oh0),
        .active      (a0),
        .event_count (ev0)
    );

    priority_code_decoder #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u1 (
        .clk         (clk),
        .rst         (rst),
        .code_in     (code1),
        .code_valid  (v1),
        .code_ready  (r1),
        .onehot_out  (oh1),
        .active      (a1),
        .event_count (ev1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready0(input int bound);
        int n = 0;
        while (!r0 && n < bound) begin
            tick();
            n++;
        end
        check("ready_timeout", 32'(r0), 32'd1);
    endtask

    initial begin
        int n;
        tbl = '{'{4'h0, 16'h0001}, '{4'h1, 16'h0002}, '{4'h2, 16'h0004}, '{4'h3, 16'h0008},
                '{4'h4, 16'h0010}, '{4'h5, 16'h0020}, '{4'h6, 16'h0040}, '{4'h7, 16'h0080},
                '{4'h8, 16'h0100}, '{4'h9, 16'h0200}, '{4'hA, 16'h0400}, '{4'hB, 16'h0800},
                '{4'hC, 16'h1000}, '{4'hD, 16'h2000}, '{4'hE, 16'h4000}, '{4'hF, 16'h8000}};
        code0 = '0; code1 = '0; v0 = 1'b0; v1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", 32'(r0), 32'd1);
        check("rst_onehot", 32'(oh0), 32'h0);
        check("rst_active", 32'(a0), 32'd0);
        check("rst_count", 32'(ev0), 32'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("idle_stable", {6'd0, r0, a0, oh0, ev0}, {6'd0, 1'b1, 1'b0, 16'h0, 8'h0});
        end
        // single code F with default hold/gap
        code0 = 4'hF; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        check("single_onehot", 32'(oh0), 32'h8000);
        check("single_active", 32'(a0), 32'd1);
        check("single_ready", 32'(r0), 32'd0);
        check("single_count", 32'(ev0), 32'd1);
        for (int k = 1; k < 4; k++) begin
            tick();
            check("single_hold", 32'(oh0), 32'h8000);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            check("single_gap", {15'd0, r0, oh0}, 32'h0);
        end
        tick();
        check("single_ready_back", 32'(r0), 32'd1);
        // back-to-back with valid held high
        code0 = 4'h0; v0 = 1'b1;
        tick();
        check("b2b_first", 32'(oh0), 32'h0001);
        code0 = 4'h9;
        n = 0;
        while (oh0 !== 16'h0200 && n < 20) begin
            tick();
            n++;
        end
        v0 = 1'b0;
        check("b2b_spacing", 32'(n), 32'd7);
        check("b2b_second", 32'(oh0), 32'h0200);
        check("b2b_count", 32'(ev0), 32'd3);
        wait_ready0(20);
        // HOLD=1, GAP=0 instance: 2-cycle accept period
        code1 = 4'h3; v1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("fast_onehot", 32'(oh1), (k % 2 == 0) ? 32'h0008 : 32'h0);
            check("fast_ready", 32'(r1), 32'(k % 2));
        end
        v1 = 1'b0;
        check("fast_count", 32'(ev1), 32'd3);
        // asynchronous reset in the middle of HOLD
        code0 = 4'h5; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        check("arst_pre", 32'(oh0), 32'h0020);
        tick();
        #1 rst = 1'b1;
        #1;
        check("arst_onehot", 32'(oh0), 32'h0);
        check("arst_active", 32'(a0), 32'd0);
        check("arst_count", 32'(ev0), 32'd0);
        check("arst_ready", 32'(r0), 32'd1);
        rst = 1'b0;
        code0 = 4'h5; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        check("arst_reaccept", 32'(oh0), 32'h0020);
        check("arst_recount", 32'(ev0), 32'd1);
        wait_ready0(20);
        // 257 accepts across every code, counter wraps
        rst = 1'b1;
        #2 rst = 1'b0;
        check("wrap_start", 32'(ev0), 32'd0);
        for (int i = 0; i < 257; i++) begin
            wait_ready0(20);
            code0 = tbl[i % 16].code; v0 = 1'b1;
            tick();
            v0 = 1'b0;
            check("wrap_onehot", 32'(oh0), 32'(tbl[i % 16].exp));
            if (i == 255) check("wrap_zero", 32'(ev0), 32'd0);
        end
        check("wrap_count", 32'(ev0), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
